// File: rtl/aes_pkg.sv
// Shared AES-128 key schedule types, constants and byte-level helpers.
// Used by keycal and aes_key_expand_ctrl.
package aes_pkg;

    localparam int AES_KEY_W = 128;
    localparam int AES_NR    = 10;

    typedef enum logic {
        ST_IDLE,
        ST_EXPAND
    } state_t;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // S-box computed as affine(x^254); x^254 is the field inverse
    // (and maps 0 to 0), formed as x^2 * x^4 * ... * x^128.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = gf_mul(x, x);
        inv = sq;
        for (int k = 2; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        logic [7:0] r;
        case (n)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/keycal.sv
// Single AES-128 key schedule step: round key n from round key n-1.
// Ports: cur (previous round key), round (1..10, rcon select), nxt (next key).
module keycal
    import aes_pkg::*;
(
    input  logic [127:0] cur,
    input  logic [3:0]   round,
    output logic [127:0] nxt
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;

    assign w0 = cur[127:96];
    assign w1 = cur[95:64];
    assign w2 = cur[63:32];
    assign w3 = cur[31:0];

    // SubWord(RotWord(w3)) xor rcon in the top byte.
    assign t = {sbox(w3[23:16]), sbox(w3[15:8]),
                sbox(w3[7:0]),   sbox(w3[31:24])}
             ^ {rcon(round), 24'h000000};

    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign nxt = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_expand_ctrl.sv
// AES-128 key expansion sequencer: one round key per clock into an
// 11-slot register file, with start/busy/done, key stream and read port.
// Ports: clk, rst (async high), start, key_in, busy, done, keys_ok,
//        rk_valid, rk_round, rk_out, rd_idx, rd_key.
module aes_key_expand_ctrl
    import aes_pkg::*;
#(
    parameter int KEY_W      = AES_KEY_W,
    parameter int NUM_ROUNDS = AES_NR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             done,
    output logic             keys_ok,
    output logic             rk_valid,
    output logic [3:0]       rk_round,
    output logic [KEY_W-1:0] rk_out,
    input  logic [3:0]       rd_idx,
    output logic [KEY_W-1:0] rd_key
);

    localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

    state_t           state;
    logic [3:0]       round;
    logic [KEY_W-1:0] cur;
    logic [KEY_W-1:0] nxt;
    logic [KEY_W-1:0] slot [NUM_ROUNDS+1];

    // One keycal shared by every round; round drives its rcon select.
    keycal u_keycal (
        .cur   (cur),
        .round (round),
        .nxt   (nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            round    <= 4'd0;
            cur      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            keys_ok  <= 1'b0;
            rk_valid <= 1'b0;
            rk_round <= 4'd0;
            rk_out   <= '0;
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                slot[i] <= '0;
            end
        end else begin
            done     <= 1'b0;
            rk_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_EXPAND;
                        slot[0]  <= key_in;
                        cur      <= key_in;
                        round    <= 4'd1;
                        keys_ok  <= 1'b0;
                        busy     <= 1'b1;
                        rk_valid <= 1'b1;
                        rk_round <= 4'd0;
                        rk_out   <= key_in;
                    end
                end
                ST_EXPAND: begin
                    slot[round] <= nxt;
                    cur         <= nxt;
                    rk_valid    <= 1'b1;
                    rk_round    <= round;
                    rk_out      <= nxt;
                    if (round == LAST) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        keys_ok <= 1'b1;
                    end else begin
                        round <= round + 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_key = '0;
        if (rd_idx <= LAST) begin
            rd_key = slot[rd_idx];
        end
    end

endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// Randomised, self-checking bench for aes_key_expand_ctrl against a
// word-level FIPS-197 key schedule model.
module tb_aes_key_expand_ctrl;

    localparam int NR = 10;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic         keys_ok;
    logic         rk_valid;
    logic [3:0]   rk_round;
    logic [127:0] rk_out;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    aes_key_expand_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .done     (done),
        .keys_ok  (keys_ok),
        .rk_valid (rk_valid),
        .rk_round (rk_round),
        .rk_out   (rk_out),
        .rd_idx   (rd_idx),
        .rd_key   (rd_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sb [256];

    function automatic logic [7:0] mul(input logic [7:0] a,
                                       input logic [7:0] b);
        int p;
        int x;
        p = 0;
        x = int'(a);
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x << 1;
            if (x >= 256) x = x ^ 'h11b;
        end
        return 8'(p);
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] s;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                     ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
            end
            sb[x] = s;
        end
    endtask

    typedef logic [127:0] sched_t [NR+1];

    function automatic sched_t expand(input logic [127:0] key);
        logic [31:0] w [4*(NR+1)];
        logic [31:0] t;
        logic [7:0]  r;
        sched_t      s;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 4*(NR+1); i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                r = 8'h01;
                for (int j = 1; j < i / 4; j++) r = mul(r, 8'h02);
                t = t ^ {r, 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k <= NR; k++) begin
            s[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        end
        return s;
    endfunction

    sched_t       sched;
    logic [127:0] mem [NR+1];
    bit           m_busy = 0;
    int           m_cnt = 0;
    bit           m_done = 0;
    bit           m_ok = 0;
    bit           m_valid = 0;
    int           m_round = 0;
    logic [127:0] m_out = '0;

    initial for (int i = 0; i <= NR; i++) mem[i] = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_cnt = 0; m_done = 0; m_ok = 0;
            m_valid = 0; m_round = 0; m_out = '0;
            for (int i = 0; i <= NR; i++) mem[i] = '0;
        end else begin
            m_done = 0;
            m_valid = 0;
            if (m_busy) begin
                mem[m_cnt] = sched[m_cnt];
                m_valid = 1;
                m_round = m_cnt;
                m_out = sched[m_cnt];
                if (m_cnt == NR) begin
                    m_busy = 0; m_done = 1; m_ok = 1;
                end else begin
                    m_cnt++;
                end
            end else if (start) begin
                sched = expand(key_in);
                mem[0] = key_in;
                m_busy = 1; m_cnt = 1; m_ok = 0;
                m_valid = 1; m_round = 0; m_out = key_in;
            end
        end
    end

    bit chk_en = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 128'(busy), 128'(m_busy));
            chk("done", 128'(done), 128'(m_done));
            chk("keys_ok", 128'(keys_ok), 128'(m_ok));
            chk("rk_valid", 128'(rk_valid), 128'(m_valid));
            if (m_valid) begin
                chk("rk_round", 128'(rk_round), 128'(m_round));
                chk("rk_out", rk_out, m_out);
            end
            chk("rd_key", rd_key, (rd_idx <= 4'(NR)) ? mem[rd_idx] : '0);
        end
    end

    bit rand_rd = 0;
    always @(posedge clk) begin
        #2;
        if (rand_rd) rd_idx = 4'($urandom_range(0, 15));
    end

    // ---------------- stimulus helpers ----------------
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called about 2 time units after a rising edge.
    task automatic start_run(input logic [127:0] key);
        start = 1'b1;
        key_in = key;
        @(posedge clk);
        #2;
        start = 1'b0;
        key_in = rnd128();
    endtask

    // Edges counted from the accepting edge until done is seen.
    task automatic wait_done(output int n);
        n = 0;
        while (n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
        end
    endtask

    int n;
    int dcnt;
    int dpos;
    logic [127:0] kb;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        key_in = '0;
        rd_idx = 4'd0;
        build_sbox();

        // model pins from FIPS-197
        sched = expand(FIPS_KEY);
        chk("model_fips_r1", sched[1], FIPS_R1);
        chk("model_fips_r10", sched[10], FIPS_R10);
        sched = expand('0);
        chk("model_zero_r1", sched[1], ZERO_R1);
        chk("model_zero_r10", sched[10], ZERO_R10);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_keys_ok", 128'(keys_ok), 128'(0));
        chk("rst_rk_valid", 128'(rk_valid), 128'(0));
        chk("rst_rk_out", rk_out, '0);
        chk("rst_rd_key", rd_key, '0);
        #1;
        rst = 1'b0;
        chk_en = 1;
        @(posedge clk);
        #2;

        // FIPS-197 key, single start pulse
        start_run(FIPS_KEY);
        wait_done(n);
        chk("fips_done_latency", 128'(n), 128'(10));
        #1;
        rd_idx = 4'd1;
        #1 chk("fips_rd1", rd_key, FIPS_R1);
        rd_idx = 4'd10;
        #1 chk("fips_rd10", rd_key, FIPS_R10);
        @(posedge clk);
        #2;

        // all-zero key
        start_run('0);
        wait_done(n);
        chk("zero_done_latency", 128'(n), 128'(10));
        @(posedge clk);
        #2;
        rd_idx = 4'd1;
        #1 chk("zero_rd1", rd_key, ZERO_R1);
        rd_idx = 4'd10;
        #1 chk("zero_rd10", rd_key, ZERO_R10);
        chk("zero_keys_ok", 128'(keys_ok), 128'(1));
        @(posedge clk);
        #2;

        // start pulses while busy are ignored
        start_run(FIPS_KEY);
        dcnt = 0;
        dpos = 0;
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                dcnt++;
                dpos = i;
            end
            if (i == 3 || i == 7) begin
                #1;
                start = 1'b1;
                key_in = rnd128();
            end
        end
        chk("ignore_done_count", 128'(dcnt), 128'(1));
        chk("ignore_done_pos", 128'(dpos), 128'(10));
        #1;
        rd_idx = 4'd10;
        #1 chk("ignore_rd10", rd_key, FIPS_R10);
        @(posedge clk);
        #2;

        // start held across done: restart on the done cycle
        start = 1'b1;
        key_in = FIPS_KEY;
        @(posedge clk);
        #2;
        wait_done(n);
        chk("held_done_latency", 128'(n), 128'(10));
        chk("held_keys_ok_hi", 128'(keys_ok), 128'(1));
        kb = rnd128();
        #1;
        key_in = kb;
        @(posedge clk);
        #1;
        chk("held_restart_busy", 128'(busy), 128'(1));
        chk("held_keys_ok_lo", 128'(keys_ok), 128'(0));
        chk("held_rk_out0", rk_out, kb);
        #1;
        start = 1'b0;
        wait_done(n);
        chk("held2_done_latency", 128'(n), 128'(10));
        @(posedge clk);
        #2;

        // reset during round 5
        start_run(rnd128());
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_keys_ok", 128'(keys_ok), 128'(0));
        chk("midrst_rk_valid", 128'(rk_valid), 128'(0));
        for (int i = 0; i <= 10; i++) begin
            rd_idx = 4'(i);
            #1 chk($sformatf("midrst_rd%0d", i), rd_key, '0);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;
        start_run(FIPS_KEY);
        wait_done(n);
        chk("postrst_done_latency", 128'(n), 128'(10));
        #1;
        rd_idx = 4'd10;
        #1 chk("postrst_rd10", rd_key, FIPS_R10);
        @(posedge clk);
        #2;

        // random keys, random gaps, random read indices
        rand_rd = 1;
        repeat (6) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #2;
            start_run(rnd128());
            wait_done(n);
            chk("rand_done_latency", 128'(n), 128'(10));
            @(posedge clk);
            #2;
        end
        rand_rd = 0;
        @(posedge clk);
        #3;

        // read sweep after a completed run
        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i);
            #1;
            chk($sformatf("sweep_rd%0d", i), rd_key,
                (i <= NR) ? mem[i] : '0);
        end

        @(posedge clk);
        #2;
        chk_en = 0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
